// File: rtl/uart_tx_even_parity_if.sv
// +-----------------------------------------------------------------------------+
// | Module      : uart_tx_even_parity_if                                        |
// | Description : Byte handshake and serial status bundle for the UART TX.     |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

interface uart_tx_even_parity_if;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       tx;
   logic       tx_busy;
   logic       tx_done;

   modport master (
      output tx_data,
      output tx_valid,
      input  tx_ready,
      input  tx,
      input  tx_busy,
      input  tx_done
   );

   modport slave (
      input  tx_data,
      input  tx_valid,
      output tx_ready,
      output tx,
      output tx_busy,
      output tx_done
   );
endinterface

`default_nettype wire

// File: rtl/uart_tx_even_parity.sv
// +-----------------------------------------------------------------------------+
// | Module      : uart_tx_even_parity                                           |
// | Description : 8-bit LSB-first UART transmitter, one-byte holding register,  |
// |               one stop bit; even parity bit built when UART_TX_PARITY_EN    |
// |               is defined.                                                   |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module uart_tx_even_parity #(
   parameter int CLKS_PER_BIT = 521
) (
   input  logic                   clk,
   input  logic                   rst,
   uart_tx_even_parity_if.slave   bus
);

   localparam int                  c_baud_w    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [c_baud_w-1:0] c_baud_last = c_baud_w'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   state_t              r_state;
   logic [7:0]          r_hold;
   logic                r_full;
   logic [7:0]          r_shift;
   logic [2:0]          r_bit_idx;
   logic [c_baud_w-1:0] r_baud;
   logic                r_tx;
`ifdef UART_TX_PARITY_EN
   logic                r_parity;
   logic                w_parity_nxt;
`endif

   state_t              w_state_nxt;
   logic                w_load;
   logic                w_accept;
   logic                w_bit_end;
   logic [7:0]          w_shift_nxt;
   logic [2:0]          w_bit_idx_nxt;
   logic [c_baud_w-1:0] w_baud_nxt;
   logic                w_tx_nxt;

   assign w_accept  = bus.tx_valid && !r_full;
   assign w_bit_end = (r_baud == c_baud_last);

   always_comb begin
      w_state_nxt   = r_state;
      w_load        = 1'b0;
      w_shift_nxt   = r_shift;
      w_bit_idx_nxt = r_bit_idx;

      case (r_state)
         IDLE: begin
            if (r_full) begin
               w_state_nxt = START;
               w_load      = 1'b1;
            end
         end
         START: begin
            if (w_bit_end) w_state_nxt = DATA;
         end
         DATA: begin
            if (w_bit_end) begin
               w_shift_nxt   = {1'b0, r_shift[7:1]};
               w_bit_idx_nxt = r_bit_idx + 3'd1;
               if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  w_state_nxt = PARITY;
`else
                  w_state_nxt = STOP;
`endif
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (w_bit_end) w_state_nxt = STOP;
         end
`endif
         STOP: begin
            // A byte waiting at the end of the stop bit starts the next frame with no gap
            if (w_bit_end) begin
               if (r_full) begin
                  w_state_nxt = START;
                  w_load      = 1'b1;
               end else begin
                  w_state_nxt = IDLE;
               end
            end
         end
         default: w_state_nxt = IDLE;
      endcase

      if (w_load) begin
         w_shift_nxt   = r_hold;
         w_bit_idx_nxt = 3'd0;
      end

      if ((r_state == IDLE) || (w_state_nxt != r_state) || w_bit_end)
         w_baud_nxt = '0;
      else
         w_baud_nxt = r_baud + 1'b1;
   end

`ifdef UART_TX_PARITY_EN
   // Parity is latched from the load value; the shift register is destroyed by shifting
   assign w_parity_nxt = w_load ? (^r_hold) : r_parity;
`endif

   // tx is registered, so its next value follows the next state
   always_comb begin
      case (w_state_nxt)
         START:   w_tx_nxt = 1'b0;
         DATA:    w_tx_nxt = w_shift_nxt[0];
`ifdef UART_TX_PARITY_EN
         PARITY:  w_tx_nxt = w_parity_nxt;
`endif
         default: w_tx_nxt = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_full    <= 1'b0;
         r_hold    <= 8'h00;
         r_shift   <= 8'h00;
         r_bit_idx <= 3'd0;
         r_baud    <= '0;
         r_tx      <= 1'b1;
`ifdef UART_TX_PARITY_EN
         r_parity  <= 1'b0;
`endif
      end else begin
         r_state   <= w_state_nxt;
         r_shift   <= w_shift_nxt;
         r_bit_idx <= w_bit_idx_nxt;
         r_baud    <= w_baud_nxt;
         r_tx      <= w_tx_nxt;
`ifdef UART_TX_PARITY_EN
         r_parity  <= w_parity_nxt;
`endif
         if (w_accept) begin
            r_hold <= bus.tx_data;
            r_full <= 1'b1;
         end else if (w_load) begin
            r_full <= 1'b0;
         end
      end
   end

   assign bus.tx       = r_tx;
   assign bus.tx_ready = !r_full;
   assign bus.tx_busy  = (r_state != IDLE) || r_full;
   assign bus.tx_done  = (r_state == STOP) && w_bit_end;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_even_parity.sv
// +-----------------------------------------------------------------------------+
// | Module      : tb_uart_tx_even_parity                                        |
// | Description : Self-checking bench for uart_tx_even_parity (frame model).   |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_uart_tx_even_parity;

   localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
   localparam int FRAME_BITS = 11;
`else
   localparam int FRAME_BITS = 10;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   uart_tx_even_parity_if bus();

   uart_tx_even_parity #(.CLKS_PER_BIT(CPB)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_checks = 0;
   int n_errors = 0;

   logic [7:0] byte_q[$];
   logic       exp_tx_q[$];
   logic       exp_done_q[$];

   // Model: each byte becomes a list of line levels, each held for CPB cycles
   function automatic void push_frame(input logic [7:0] b);
      logic bits[$];
      bits.push_back(1'b0);
      for (int i = 0; i < 8; i++) bits.push_back(b[i]);
`ifdef UART_TX_PARITY_EN
      bits.push_back(($countones(b) % 2) == 1);
`endif
      bits.push_back(1'b1);
      for (int k = 0; k < bits.size(); k++)
         for (int j = 0; j < CPB; j++) begin
            exp_tx_q.push_back(bits[k]);
            exp_done_q.push_back((k == FRAME_BITS - 1) && (j == CPB - 1));
         end
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      bus.tx_valid = 1'b1;
      bus.tx_data  = 8'($urandom);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         n_checks++;
         if (bus.tx !== 1'b1 || bus.tx_ready !== 1'b1 || bus.tx_busy !== 1'b0 || bus.tx_done !== 1'b0) begin
            n_errors++;
            $display("FAIL reset cyc %0d got tx=%b ready=%b busy=%b done=%b exp 1 1 0 0",
                     c, bus.tx, bus.tx_ready, bus.tx_busy, bus.tx_done);
         end
      end
      rst = 1'b0;
      bus.tx_valid = 1'b0;
      @(negedge clk);
      n_checks++;
      if (bus.tx_busy !== 1'b0 || bus.tx_ready !== 1'b1 || bus.tx !== 1'b1) begin
         n_errors++;
         $display("FAIL reset_release got busy=%b ready=%b tx=%b exp 0 1 1",
                  bus.tx_busy, bus.tx_ready, bus.tx);
      end
   endtask

   // Sends byte_q with valid held high, advancing on tx_ready; scramble changes
   // tx_data whenever the block is not ready so held bytes must be unaffected
   task automatic test_stream(input bit scramble, input string name);
      int idx = 0;
      int done_cnt = 0;
      int len;
      logic e_tx, e_done, e_busy;
      exp_tx_q   = {};
      exp_done_q = {};
      foreach (byte_q[i]) push_frame(byte_q[i]);
      len = exp_tx_q.size();
      @(negedge clk);
      for (int c = 0; c < len + 6; c++) begin
         if (c < 2) begin
            e_tx = 1'b1; e_done = 1'b0; e_busy = (c == 1);
         end else if (c < len + 2) begin
            e_tx = exp_tx_q[c-2]; e_done = exp_done_q[c-2]; e_busy = 1'b1;
         end else begin
            e_tx = 1'b1; e_done = 1'b0; e_busy = 1'b0;
         end
         n_checks++;
         if (bus.tx !== e_tx) begin
            n_errors++;
            $display("FAIL %s tx cyc %0d got %b exp %b", name, c, bus.tx, e_tx);
         end
         n_checks++;
         if (bus.tx_done !== e_done) begin
            n_errors++;
            $display("FAIL %s tx_done cyc %0d got %b exp %b", name, c, bus.tx_done, e_done);
         end
         n_checks++;
         if (bus.tx_busy !== e_busy) begin
            n_errors++;
            $display("FAIL %s tx_busy cyc %0d got %b exp %b", name, c, bus.tx_busy, e_busy);
         end
         if (c < 2) begin
            n_checks++;
            if (bus.tx_ready !== (c == 0)) begin
               n_errors++;
               $display("FAIL %s tx_ready cyc %0d got %b exp %b", name, c, bus.tx_ready, (c == 0));
            end
         end
         if (bus.tx_done === 1'b1) done_cnt++;

         if (idx < byte_q.size()) begin
            bus.tx_valid = 1'b1;
            bus.tx_data  = (bus.tx_ready || !scramble) ? byte_q[idx] : 8'($urandom);
            if (bus.tx_ready) idx++;
         end else begin
            bus.tx_valid = scramble && !bus.tx_ready;
            bus.tx_data  = 8'($urandom);
         end
         @(negedge clk);
      end
      bus.tx_valid = 1'b0;
      n_checks++;
      if (done_cnt != byte_q.size()) begin
         n_errors++;
         $display("FAIL %s done_count got %0d exp %0d", name, done_cnt, byte_q.size());
      end
   endtask

   task automatic test_reset_mid_frame();
      int rst_cyc = 2 + 4 * CPB + 1;   // middle of data bit 3
      @(negedge clk);
      bus.tx_valid = 1'b1;
      bus.tx_data  = 8'hFF;
      @(negedge clk);
      bus.tx_valid = 1'b0;
      for (int c = 1; c < rst_cyc; c++) @(negedge clk);
      n_checks++;
      if (bus.tx !== 1'b1 || bus.tx_busy !== 1'b1) begin
         n_errors++;
         $display("FAIL midrst_pre got tx=%b busy=%b exp 1 1", bus.tx, bus.tx_busy);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_checks++;
      if (bus.tx !== 1'b1 || bus.tx_ready !== 1'b1 || bus.tx_busy !== 1'b0 || bus.tx_done !== 1'b0) begin
         n_errors++;
         $display("FAIL midrst got tx=%b ready=%b busy=%b done=%b exp 1 1 0 0",
                  bus.tx, bus.tx_ready, bus.tx_busy, bus.tx_done);
      end
      for (int c = 0; c < 12 * CPB; c++) begin
         @(negedge clk);
         n_checks++;
         if (bus.tx !== 1'b1 || bus.tx_done !== 1'b0 || bus.tx_busy !== 1'b0) begin
            n_errors++;
            $display("FAIL midrst_after cyc %0d got tx=%b done=%b busy=%b exp 1 0 0",
                     c, bus.tx, bus.tx_done, bus.tx_busy);
         end
      end
   endtask

   initial begin
      bus.tx_valid = 1'b0;
      bus.tx_data  = 8'h00;
      test_reset();

      byte_q = {};
      byte_q.push_back(8'h0E);
      test_stream(1'b0, "byte_0E");

      byte_q = {};
      byte_q.push_back(8'h0C);
      test_stream(1'b0, "byte_0C");

      byte_q = {};
      byte_q.push_back(8'h0C);
      byte_q.push_back(8'h03);
      byte_q.push_back(8'h0E);
      test_stream(1'b0, "back_to_back");

      byte_q = {};
      byte_q.push_back(8'hA5);
      test_stream(1'b1, "held_data");

      for (int r = 0; r < 6; r++) begin
         int n = $urandom_range(1, 3);
         byte_q = {};
         for (int i = 0; i < n; i++) byte_q.push_back(8'($urandom));
         test_stream(r[0], "random");
      end

      test_reset_mid_frame();

      byte_q = {};
      byte_q.push_back(8'h5A);
      test_stream(1'b0, "after_reset");

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
